// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready request into a single APB3/APB4 transfer
// (IDLE -> SETUP -> ACCESS) and returns a one-cycle completion pulse with read data
// and error status.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort transfers whose slave holds
// PREADY low for TIMEOUT_CYCLES consecutive ACCESS samples.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_strb,
    input  logic [2:0]            req_prot,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                state_q;
    logic                  req_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    // Number of PREADY=0 samples seen so far in the current ACCESS phase.
    logic [CntW-1:0]       wait_cnt_q;
`endif

    // Transfer FSM; every bus and response output is a register updated here.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= 4'b0000;
            pprot_q     <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            // Completion pulse lasts exactly one cycle; data/err hold their last value.
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= StSetup;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= req_write;
                        paddr_q     <= req_addr;
                        pwdata_q    <= req_wdata;
                        // Reads never assert byte strobes; writes forward them verbatim.
                        pstrb_q     <= req_write ? req_strb : 4'b0000;
                        pprot_q     <= req_prot;
`ifdef APB_MASTER_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        // This sample is the TIMEOUT_CYCLES-th stall: give up.
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random and directed requests, a queue-driven
// APB slave, and a response monitor checking data, error and completion cycle.
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Count of rising edges so far; read only at falling edges.
    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int unsigned waits;   // PREADY=0 samples the slave inserts
        logic [31:0] rdata;   // slave read data
        logic        slverr;  // slave error flag
        int unsigned acc;     // edge at which the request is accepted
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        int unsigned cyc;     // edge after which rsp_valid must be seen
    } exp_t;

    txn_t slv_q[$];
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the response a transfer should produce, from the protocol rules.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.addr = t.addr;
        e.rdata = t.write ? 32'h0 : t.rdata;
        e.err   = t.slverr;
        // SETUP takes one cycle, ACCESS waits+1 cycles, response follows the last ACCESS.
        e.cyc   = t.acc + 2 + t.waits;
`ifdef APB_MASTER_TIMEOUT_EN
        if (t.waits >= TO) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
            e.cyc   = t.acc + 1 + TO;
        end
`endif
        return e;
    endfunction

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] s, input int unsigned waits,
                                input logic [31:0] rd, input bit err);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.prot = 3'($urandom);
        t.waits = waits; t.rdata = rd; t.slverr = err; t.acc = 0;
        return t;
    endfunction

    // Present one request once the bridge is ready; junk is driven while it is busy.
    task automatic issue(input txn_t t_in, input bit expect_rsp);
        txn_t t;
        int   guard;
        t = t_in;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 300) begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_strb  = 4'($urandom);
            req_prot  = 3'($urandom);
            @(negedge PCLK);
            guard++;
        end
        check("req_ready_wait", {63'd0, req_ready}, 64'd1);
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_write = t.write;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_strb  = t.strb;
        req_prot  = t.prot;
        t.acc = cyc + 1;
        slv_q.push_back(t);
        if (expect_rsp) sb_q.push_back(model(t));
        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // APB slave: replays the queued wait count and response, checks the bus fields.
    initial begin
        txn_t cur;
        int   acnt;
        int   left;
        bit   busy;
        busy = 0; acnt = 0; left = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PRESETn !== 1'b1) begin
                busy = 0;
                PREADY = 1'b0;
            end else if (PSEL && !PENABLE) begin
                check("setup_expected", {63'd0, slv_q.size() != 0}, 64'd1);
                if (slv_q.size() != 0) begin
                    cur = slv_q.pop_front();
                    busy = 1; acnt = 0; left = int'(cur.waits);
                    check("psel_edge", 64'(cyc), 64'(cur.acc));
                    check("pwrite", {63'd0, PWRITE}, {63'd0, cur.write});
                    check("paddr", 64'(PADDR), 64'(cur.addr));
                    check("pwdata", 64'(PWDATA), 64'(cur.wdata));
                    check("pstrb", 64'(PSTRB), cur.write ? 64'(cur.strb) : 64'd0);
                    check("pprot", 64'(PPROT), 64'(cur.prot));
                end
                PREADY = 1'b0;
            end else if (PSEL && PENABLE) begin
                check("access_in_txn", {63'd0, busy}, 64'd1);
                acnt++;
                if (acnt == 1) check("penable_edge", 64'(cyc), 64'(cur.acc + 1));
                check("access_paddr", 64'(PADDR), 64'(cur.addr));
                check("access_pstrb", 64'(PSTRB), cur.write ? 64'(cur.strb) : 64'd0);
                check("access_pwdata", 64'(PWDATA), 64'(cur.wdata));
                if (left > 0) begin
                    left--;
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom);
                end else begin
                    PREADY  = 1'b1;
                    PRDATA  = cur.rdata;
                    PSLVERR = cur.slverr;
                end
            end else begin
                busy = 0;
                PREADY = 1'b0;
                PSLVERR = 1'($urandom);
            end
        end
    end

    // Monitor: every rsp_valid cycle consumes exactly one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (PRESETn === 1'b1 && rsp_valid === 1'b1) begin
                check("rsp_expected", {63'd0, sb_q.size() != 0}, 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rsp_edge", 64'(cyc), 64'(e.cyc));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    check("rsp_req_ready", {63'd0, req_ready}, 64'd1);
                    check("rsp_bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
                    check("idle_paddr_held", 64'(PADDR), 64'(e.addr));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || slv_q.size() != 0) && guard < 500) begin
            @(negedge PCLK);
            guard++;
        end
        check(nm, 64'(sb_q.size() + slv_q.size()), 64'd0);
    endtask

    initial begin
        txn_t t;
        int   guard;
        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0;
        #12;
        check("reset_ctrl", {56'd0, req_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, 2'b00},
              64'd0);
        check("reset_bus", {49'd0, PSTRB, PPROT, 8'd0}, 64'd0);
        check("reset_paddr", 64'(PADDR), 64'd0);
        check("reset_pwdata", 64'(PWDATA), 64'd0);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ready_after_reset", {63'd0, req_ready}, 64'd1);

        // Directed: zero-wait write, read with strobes, 3 wait states, slave error, strb 0.
        issue(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h1234_5678, 1'b0), 1'b1);
        issue(mk(1'b0, 32'h20, 32'h0BAD_F00D, 4'hF, 0, 32'hDEADBEEF, 1'b0), 1'b1);
        issue(mk(1'b0, 32'h24, 32'h0, 4'h3, 3, 32'hCAFE_0001, 1'b0), 1'b1);
        issue(mk(1'b1, 32'h28, 32'h5555_AAAA, 4'h5, 1, 32'h0, 1'b1), 1'b1);
        issue(mk(1'b1, 32'h2C, 32'h7777_0000, 4'h0, 0, 32'hFFFF_FFFF, 1'b0), 1'b1);
        drain("drain_directed");

        // Random traffic, sometimes back-to-back, sometimes with idle gaps.
        for (int i = 0; i < 60; i++) begin
            int unsigned w;
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
`ifdef APB_MASTER_TIMEOUT_EN
            if ($urandom_range(0, 9) == 0) w = $urandom_range(TO, TO + 4);
`endif
            t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), w, $urandom,
                   ($urandom_range(0, 4) == 0));
            issue(t, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
        drain("drain_random");

`ifdef APB_MASTER_TIMEOUT_EN
        issue(mk(1'b0, 32'h40, 32'h0, 4'hF, 100, 32'h1111_2222, 1'b0), 1'b1);
        drain("drain_timeout");
`endif

        // Reset asserted in the middle of a waiting ACCESS phase.
        issue(mk(1'b0, 32'h80, 32'h0, 4'hF, 8, 32'h9999_8888, 1'b0), 1'b0);
        guard = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("reached_access", {62'd0, PSEL, PENABLE}, 64'd3);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midreset_ctrl", {59'd0, PSEL, PENABLE, req_ready, rsp_valid, rsp_err}, 64'd0);
        check("midreset_paddr", 64'(PADDR), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("ready_after_midreset", {63'd0, req_ready}, 64'd1);
        repeat (10) @(negedge PCLK);
        check("midreset_no_rsp", 64'(sb_q.size() + slv_q.size()), 64'd0);

        issue(mk(1'b0, 32'h84, 32'h0, 4'h9, 2, 32'hABCD_EF01, 1'b0), 1'b1);
        drain("drain_after_reset");
        repeat (3) @(negedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PADDR/req_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning PWDATA/PRDATA/req_wdata/rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the wait-state limit used only under APB_MASTER_TIMEOUT_EN.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with these ports: PCLK  in  1  clock, all logic on rising edge; PRESETn  in  1  asynchronous active-low reset.
REQ-005 SHALL have these request ports: req_valid  in  1  request present; req_ready  out  1  bridge accepts; req_write  in  1  1=write 0=read; req_addr  in  ADDR_WIDTH  address; req_wdata  in  DATA_WIDTH  write data; req_strb  in  4  byte strobes; req_prot  in  3  protection.
REQ-006 SHALL have these response ports: rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_WIDTH  read data; rsp_err  out  1  transfer error.
REQ-007 SHALL have these APB ports: PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  4; PPROT  out  3; PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

Function
REQ-008 SHALL implement the FSM states IDLE, SETUP and ACCESS, held in registers.
REQ-009 SHALL drive req_ready=1 in IDLE only, with no combinational path from req_valid.
REQ-010 SHALL accept a request in IDLE when req_valid && req_ready, register all req_* fields and move to SETUP.
REQ-011 SHALL, in SETUP, drive PSEL=1 and PENABLE=0 from the registered fields, then unconditionally move to ACCESS.
REQ-012 SHALL, in ACCESS, drive PSEL=1 and PENABLE=1 and hold PADDR/PWRITE/PWDATA/PSTRB/PPROT stable until completion.
REQ-013 SHALL complete a transfer at the first ACCESS-cycle rising edge with PREADY=1, capturing PRDATA and PSLVERR and returning to IDLE.
REQ-014 SHALL pulse rsp_valid high for exactly one cycle, the cycle after completion, with no backpressure on the response.
REQ-015 SHALL set rsp_rdata to the captured PRDATA for reads and 0 for writes, and rsp_err to the captured PSLVERR.
REQ-016 SHALL give zero-wait-state latency as follows: accept at edge N, SETUP cycle N..N+1, ACCESS N+1..N+2, rsp_valid high N+2..N+3, req_ready high again from N+2.
REQ-017 SHALL add one ACCESS cycle per PREADY=0 sample, with unbounded waiting when the timeout is not compiled in.
REQ-018 SHALL force PSTRB=4'b0000 on reads regardless of req_strb, and forward req_strb unchanged on writes, including 4'b0000.
REQ-019 SHALL drive PSEL=0 and PENABLE=0 in IDLE, with PADDR/PWRITE/PWDATA/PSTRB/PPROT retaining their last values.
REQ-020 SHALL, for back-to-back requests, insert at least one IDLE cycle between transfers and never go ACCESS->SETUP directly.
REQ-021 SHALL ignore req_valid and all req_* changes outside IDLE.
REQ-022 SHALL hold rsp_rdata and rsp_err at their last values while rsp_valid=0.

Reset
REQ-023 SHALL, on PRESETn=0, asynchronously force state IDLE and all outputs to 0: req_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata and rsp_err.
REQ-024 SHALL, when reset asserts mid-transfer, abandon the transfer with no rsp_valid for it, and drive req_ready=1 on the first edge after PRESETn deasserts.

Configuration
REQ-025 SHALL, with macro APB_MASTER_TIMEOUT_EN defined, count consecutive ACCESS cycles sampling PREADY=0.
REQ-026 SHALL, when that count reaches TIMEOUT_CYCLES, return to IDLE, drop PSEL/PENABLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0, resetting the counter on every transfer start.
REQ-027 SHALL, with APB_MASTER_TIMEOUT_EN undefined, contain no counter logic and leave TIMEOUT_CYCLES unused.

Verification
REQ-028 SHALL cover a write with PREADY tied 1: req addr=0x10, wdata=0xDEADBEEF, strb=4'hF -> PSEL rises N+1, PENABLE N+2, PSTRB=4'hF, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-029 SHALL cover a read with req_strb=4'hF and slave PRDATA=0xDEADBEEF -> PSTRB=0 throughout, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 SHALL cover 3 PREADY=0 wait states on a read -> 4 ACCESS cycles, stable PADDR, a single rsp_valid pulse.
REQ-031 SHALL cover PSLVERR=1 at completion -> rsp_err=1 for one rsp_valid pulse, followed by req_ready=1.
REQ-032 SHALL cover PRESETn pulsed low during ACCESS -> PSEL=PENABLE=0 immediately, no rsp_valid, req_ready=1 on the first edge after release.
REQ-033 SHALL cover, under APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=16, PREADY held 0 -> 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
